posit_encode_pipe: RTL and testbench

Two-stage pipelined posit encoder: packs sign, regime (rc/regime-magnitude form), exponent and fraction fields back into an N-bit posit word with round-to-nearest-even, maxpos/minpos saturation and two's-complement negation. Sits directly downstream of the field-extraction and arithmetic datapath: it accepts the same `rc`/`regime`/`exp`/`mant` field convention that the decode path produces and `reg_exp_op` feeds, and emits the final posit. It uses a valid/ready handshake with full-throughput backpressure.

---
 rtl/posit_pkg.sv | 33 +++
 rtl/DSR_right_N_S.sv | 25 ++
 rtl/posit_round_sat.sv | 41 ++++
 rtl/posit_encode_pipe.sv | 117 +++++++++++
 tb/tb_posit_encode_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/posit_pkg.sv
// Shared types and constants for the posit encode path.
package posit_pkg;

  // Ceiling log2 for elaboration-time sizing (log2(1) = 0).
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int POSIT_N  = 16;
  localparam int POSIT_ES = 2;
  localparam int POSIT_BS = log2(POSIT_N);

  localparam logic [POSIT_N-1:0] POSIT_ZERO        = '0;
  localparam logic [POSIT_N-1:0] POSIT_NAR         = {1'b1, {(POSIT_N-1){1'b0}}};
  localparam logic [POSIT_N-2:0] POSIT_MAXPOS_BODY = '1;
  localparam logic [POSIT_N-2:0] POSIT_MINPOS_BODY = {{(POSIT_N-2){1'b0}}, 1'b1};

  // Stage-1 payload: truncated body plus everything needed to round it.
  typedef struct packed {
    logic               sign;
    logic [POSIT_N-2:0] body;
    logic               guard;
    logic               sticky;
    logic               zero;
    logic               nar;
  } s1_t;

endpackage

// File: rtl/DSR_right_N_S.sv
// Logarithmic logical right shifter: N-bit data, S-bit shift amount.
module DSR_right_N_S #(
  parameter int N = 32,
  parameter int S = 5
) (
  input  logic [N-1:0] a,
  input  logic [S-1:0] b,
  output logic [N-1:0] c
);

  logic [N-1:0] stage [S+1];

  assign stage[0] = a;

  // Each level shifts by a power of two when its amount bit is set.
  genvar gi;
  generate
    for (gi = 0; gi < S; gi++) begin : g_stage
      assign stage[gi+1] = b[gi] ? (stage[gi] >> (1 << gi)) : stage[gi];
    end
  endgenerate

  assign c = stage[S];

endmodule

// File: rtl/posit_round_sat.sv
// Stage-2 combinational logic: RNE increment, clamp, negate, special-case mux.
module posit_round_sat
  import posit_pkg::*;
(
  input  s1_t                s1,
  output logic [POSIT_N-1:0] word
);

  localparam int N = POSIT_N;

  logic         round_up;
  logic [N-1:0] sum;
  logic [N-2:0] body_sat;
  logic [N-1:0] magnitude;

  assign round_up = s1.guard & (s1.body[0] | s1.sticky);
  assign sum      = {1'b0, s1.body} + N'(round_up);

  // Carry out of the body would alias NaR; a zero body would alias zero.
  always_comb begin
    body_sat = sum[N-2:0];
    if (sum[N-1]) begin
      body_sat = POSIT_MAXPOS_BODY;
    end else if (sum[N-2:0] == '0) begin
      body_sat = POSIT_MINPOS_BODY;
    end
  end

  assign magnitude = {1'b0, body_sat};

  // Specials override everything; otherwise negate the whole word for sign.
  always_comb begin
    word = s1.sign ? (~magnitude + N'(1)) : magnitude;
    if (s1.nar) begin
      word = POSIT_NAR;
    end else if (s1.zero) begin
      word = POSIT_ZERO;
    end
  end

endmodule

// File: rtl/posit_encode_pipe.sv
// Two-stage posit encoder with valid/ready flow control.
// S1 builds the magnitude string and truncates it; S2 rounds and negates.
module posit_encode_pipe
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int es = POSIT_ES,
  parameter int Bs = log2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic          in_rc,
  input  logic [Bs-1:0] in_regime,
  input  logic [es-1:0] in_exp,
  input  logic [N-es-1:0] in_mant,
  input  logic          in_sticky,
  input  logic          in_zero,
  input  logic          in_nar,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit
);

  // The string never exceeds 2N bits when not saturating, so nothing is lost.
  localparam int L  = 2 * N;
  localparam int SW = Bs + 1;

  logic         s1_valid_reg;
  s1_t          s1_reg;
  s1_t          s1_next;
  logic         out_valid_reg;
  logic [N-1:0] out_posit_reg;
  logic [N-1:0] round_word;
  logic         s2_load;
  logic         s1_load;

  logic [SW-1:0] run_len;
  logic [L-1:0]  seed;
  logic [L-1:0]  payload;
  logic [L-1:0]  shifted;
  logic [L-1:0]  mag_string;
  logic          sat_max;
  logic          sat_min;

  assign s2_load  = !out_valid_reg || out_ready;
  assign s1_load  = !s1_valid_reg || s2_load;
  assign in_ready = s1_load && !rst;

  // Regime run: rc=1 gives regime+1 ones, rc=0 gives regime zeros; the
  // terminator is the complement of the run bit and leads the payload.
  assign run_len = in_rc ? (SW'(in_regime) + SW'(1)) : SW'(in_regime);
  assign seed    = {L{in_rc}};
  assign payload = {~in_rc, in_exp, in_mant, {(N-1){1'b0}}};

  // Shifting the seed-inverted payload then re-inverting fills with the run bit.
  DSR_right_N_S #(.N(L), .S(SW)) u_regime_shift (
    .a (payload ^ seed),
    .b (run_len),
    .c (shifted)
  );

  assign mag_string = shifted ^ seed;
  assign sat_max    = in_rc && (in_regime >= Bs'(N-2));
  assign sat_min    = !in_rc && (in_regime >= Bs'(N-1));

  // Truncate the string into body/guard/sticky, or pin the saturated body.
  always_comb begin
    s1_next.sign   = in_sign;
    s1_next.zero   = in_zero;
    s1_next.nar    = in_nar;
    s1_next.body   = mag_string[L-1 -: N-1];
    s1_next.guard  = mag_string[L-N];
    s1_next.sticky = (|mag_string[L-N-1:0]) | in_sticky;
    if (sat_max) begin
      s1_next.body   = POSIT_MAXPOS_BODY;
      s1_next.guard  = 1'b0;
      s1_next.sticky = 1'b0;
    end else if (sat_min) begin
      s1_next.body   = POSIT_MINPOS_BODY;
      s1_next.guard  = 1'b0;
      s1_next.sticky = 1'b0;
    end
  end

  // S1 register: advances whenever it is empty or S2 can take its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
    end else if (s1_load) begin
      s1_valid_reg <= in_valid;
      if (in_valid) s1_reg <= s1_next;
    end
  end

  posit_round_sat u_round_sat (
    .s1   (s1_reg),
    .word (round_word)
  );

  // S2 register: holds the result steady while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_posit_reg <= '0;
    end else if (s2_load) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) out_posit_reg <= round_word;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_posit = out_posit_reg;

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Self-checking bench for posit_encode_pipe (N=16, es=2).
module tb_posit_encode_pipe;

  typedef struct packed {
    logic        sign;
    logic        rc;
    logic [3:0]  regime;
    logic [1:0]  exp;
    logic [13:0] mant;
    logic        sticky;
    logic        zero;
    logic        nar;
  } fields_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic        in_rc;
  logic [3:0]  in_regime;
  logic [1:0]  in_exp;
  logic [13:0] in_mant;
  logic        in_sticky;
  logic        in_zero;
  logic        in_nar;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_posit;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  logic [15:0] exp_next;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  bit          rand_done;

  always #5 clk = ~clk;

  posit_encode_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_rc     (in_rc),
    .in_regime (in_regime),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_sticky (in_sticky),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  // Reference: spell out the bit string, cut it, round it with integers.
  function automatic logic [15:0] model(input fields_t f);
    bit q[$];
    int body;
    int guard;
    int sticky;
    if (f.nar) return 16'h8000;
    if (f.zero) return 16'h0000;
    if (f.rc && f.regime >= 14) begin
      body = 'h7FFF;
    end else if (!f.rc && f.regime >= 15) begin
      body = 1;
    end else begin
      if (f.rc) begin
        for (int i = 0; i <= int'(f.regime); i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < int'(f.regime); i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = 1; i >= 0; i--) q.push_back(f.exp[i]);
      for (int i = 13; i >= 0; i--) q.push_back(f.mant[i]);
      body = 0;
      for (int i = 0; i < 15; i++) body = body * 2 + int'(q[i]);
      guard  = int'(q[15]);
      sticky = int'(f.sticky);
      for (int i = 16; i < q.size(); i++) sticky = sticky | int'(q[i]);
      if (guard == 1 && ((body % 2) == 1 || sticky == 1)) body = body + 1;
      if (body > 'h7FFF) body = 'h7FFF;
      if (body == 0) body = 1;
    end
    return f.sign ? 16'((65536 - body) % 65536) : 16'(body);
  endfunction

  function automatic fields_t mk(input logic s, input logic rc, input logic [3:0] r,
                                 input logic [1:0] e, input logic [13:0] m,
                                 input logic st, input logic z, input logic n);
    fields_t f;
    f = '{sign: s, rc: rc, regime: r, exp: e, mant: m, sticky: st, zero: z, nar: n};
    return f;
  endfunction

  function automatic fields_t rand_fields();
    fields_t f;
    f.sign   = 1'($urandom);
    f.rc     = 1'($urandom);
    f.regime = 4'($urandom_range(0, 15));
    f.exp    = 2'($urandom);
    f.mant   = 14'($urandom);
    f.sticky = 1'($urandom);
    f.zero   = ($urandom_range(0, 15) == 0);
    f.nar    = ($urandom_range(0, 15) == 0);
    return f;
  endfunction

  task automatic set_fields(input fields_t f, input logic [15:0] e);
    in_sign   = f.sign;
    in_rc     = f.rc;
    in_regime = f.regime;
    in_exp    = f.exp;
    in_mant   = f.mant;
    in_sticky = f.sticky;
    in_zero   = f.zero;
    in_nar    = f.nar;
    exp_next  = e;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Present one transaction and hold it until accepted (bounded).
  task automatic drive(input fields_t f, input logic [15:0] e);
    int t;
    t = 0;
    set_fields(f, e);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0, required 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: log acceptances, compare each drained result in order.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) exp_q.push_back(exp_next);
      if (out_valid && out_ready) begin
        n_out++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got %h, required no output", out_posit);
        end else begin
          mon_e = exp_q.pop_front();
          $display("out #%0d: posit=%h expected=%h", n_out, out_posit, mon_e);
          if (out_posit !== mon_e) begin
            n_fail++;
            $display("FAIL out_posit #%0d: got %h, required %h", n_out, out_posit, mon_e);
          end
        end
      end
    end
  end

  fields_t     vf[16];
  logic [15:0] ve[16];
  fields_t     bp_f[4];

  initial begin
    int acc;
    int idx;
    int base_out;
    bit stable_ok;
    bit have_held;
    logic [15:0] held;
    fields_t rf;

    vf[0]  = mk(0, 1, 4'd0,  2'd0, 14'h0000, 0, 0, 0); ve[0]  = 16'h4000;
    vf[1]  = mk(1, 1, 4'd0,  2'd0, 14'h0000, 0, 0, 0); ve[1]  = 16'hC000;
    vf[2]  = mk(0, 0, 4'd1,  2'd3, 14'h0000, 0, 0, 0); ve[2]  = 16'h3800;
    vf[3]  = mk(0, 1, 4'd0,  2'd0, 14'b00000000001_100, 0, 0, 0); ve[3] = 16'h4002;
    vf[4]  = mk(0, 1, 4'd0,  2'd0, 14'b00000000000_100, 0, 0, 0); ve[4] = 16'h4000;
    vf[5]  = mk(0, 1, 4'd0,  2'd0, 14'b00000000000_100, 1, 0, 0); ve[5] = 16'h4001;
    vf[6]  = mk(0, 1, 4'd15, 2'd0, 14'h0000, 0, 0, 0); ve[6]  = 16'h7FFF;
    vf[7]  = mk(1, 1, 4'd15, 2'd0, 14'h0000, 0, 0, 0); ve[7]  = 16'h8001;
    vf[8]  = mk(0, 0, 4'd15, 2'd0, 14'h0000, 0, 0, 0); ve[8]  = 16'h0001;
    vf[9]  = mk(0, 1, 4'd3,  2'd1, 14'h1234, 1, 1, 1); ve[9]  = 16'h8000;
    vf[10] = mk(0, 1, 4'd3,  2'd1, 14'h1234, 1, 1, 0); ve[10] = 16'h0000;
    vf[11] = mk(1, 0, 4'd2,  2'd2, 14'h0F0F, 0, 1, 0); ve[11] = 16'h0000;
    vf[12] = mk(1, 0, 4'd2,  2'd2, 14'h0F0F, 0, 0, 1); ve[12] = 16'h8000;
    vf[13] = mk(0, 1, 4'd13, 2'd3, 14'h3FFF, 0, 0, 0); ve[13] = 16'h7FFF;
    vf[14] = mk(1, 0, 4'd14, 2'd0, 14'h0000, 0, 0, 0); ve[14] = 16'hFFFF;
    vf[15] = mk(0, 1, 4'd0,  2'd3, 14'h3FFF, 0, 0, 0); ve[15] = 16'h6000;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_fields('0, 16'h0);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_posit", 32'(out_posit), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // Directed vectors, streamed back to back.
    for (int i = 0; i < 16; i++) drive(vf[i], ve[i]);
    wait_drain();

    // Random stream against the reference model with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          rf = rand_fields();
          drive(rf, model(rf));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Backpressure: downstream stalls while four inputs are offered.
    @(posedge clk);
    #1;
    base_out  = n_out;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) bp_f[i] = rand_fields();
    idx = 0;
    acc = 0;
    stable_ok = 1'b1;
    have_held = 1'b0;
    held = '0;
    set_fields(bp_f[0], model(bp_f[0]));
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (have_held && out_posit !== held) stable_ok = 1'b0;
        held = out_posit;
        have_held = 1'b1;
      end
      if (in_ready) acc++;
      @(posedge clk);
      #1;
      if (acc > idx) begin
        idx = acc;
        if (idx < 4) set_fields(bp_f[idx], model(bp_f[idx]));
      end
    end
    check("bp_accept_count", 32'(acc), 32'd2);
    check("bp_in_ready_stalled", 32'(in_ready), 32'd0);
    check("bp_out_valid_stalled", 32'(out_valid), 32'd1);
    check("bp_out_stable", 32'(stable_ok), 32'd1);
    check("bp_held_value", 32'(held), 32'(model(bp_f[0])));
    out_ready = 1'b1;
    for (int t = 0; t < 50 && idx < 4; t++) begin
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk);
      #1;
      if (acc > idx) begin
        idx = acc;
        if (idx < 4) set_fields(bp_f[idx], model(bp_f[idx]));
      end
    end
    in_valid = 1'b0;
    wait_drain();
    check("bp_output_count", 32'(n_out - base_out), 32'd4);

    // Reset with both stages full discards everything in flight.
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rf = rand_fields();
      set_fields(rf, model(rf));
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_reset_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_out_valid", 32'(out_valid), 32'd0);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    base_out = n_out;
    repeat (6) @(negedge clk);
    check("post_reset_no_output", 32'(n_out - base_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
